// File: rtl/trap_controller.sv
// Trap entry/exit sequencer for the RV32 core: arbitrates exceptions, MRET and
// masked interrupts, captures trap CSRs, and drives flush/redirect to fetch.
module trap_controller #(
  parameter int unsigned NUM_IRQ      = 16,
  parameter logic [15:0] IRQ_EDGE     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_NEST     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exc_valid,
  output logic               exc_ready,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        exc_tval,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               boundary_valid,
  input  logic [31:0]        boundary_next_pc,
  input  logic               mret_valid,
  input  logic [31:0]        mtvec,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ready,
  output logic [31:0]        mepc,
  output logic [31:0]        mcause,
  output logic [31:0]        mtval,
  output logic               mstatus_mie,
  output logic               mstatus_mpie,
  output logic [3:0]         trap_depth,
  output logic               lockup,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam logic [NUM_IRQ-1:0] EDGE_MASK  = IRQ_EDGE[NUM_IRQ-1:0];
  localparam logic [3:0]         FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0]         DEPTH_MAX  = 4'(MAX_NEST);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, LOCKUP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0]        rpc_q, rpc_d;
  logic               mie_q, mie_d, mpie_q, mpie_d;
  logic [3:0]         depth_q, depth_d;
  logic [NUM_IRQ-1:0] irq_prev_q, edge_pend_q, edge_pend_d;

  logic [NUM_IRQ-1:0] irq_elig, irq_clr;
  logic               irq_found;
  logic [3:0]         irq_idx;
  logic               idle, take_exc, take_mret, take_irq;
  logic [31:0]        vec_base, irq_cause, irq_target;

  // Lowest-index eligible interrupt line
  always_comb begin
    irq_found = 1'b0;
    irq_idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_elig[i]) begin
        irq_found = 1'b1;
        irq_idx   = 4'(i);
      end
    end
  end

  assign irq_pending = (edge_pend_q & EDGE_MASK) | (irq_lines & ~EDGE_MASK);
  assign irq_elig    = irq_pending & irq_mask;

  assign idle      = (state_q == IDLE);
  assign take_exc  = idle && exc_valid;
  assign take_mret = idle && !exc_valid && mret_valid;
  assign take_irq  = idle && !exc_valid && !mret_valid && boundary_valid && mie_q && irq_found;

  assign vec_base   = {mtvec[31:2], 2'b00};
  assign irq_cause  = {1'b1, 26'd0, 1'b1, irq_idx};
  assign irq_target = (mtvec[1:0] == 2'b01) ? vec_base + {25'd0, 1'b1, irq_idx, 2'b00} : vec_base;

  // Edge flops: a new rising edge wins over the clear from acceptance
  assign irq_clr     = take_irq ? (NUM_IRQ'(1) << irq_idx) : '0;
  assign edge_pend_d = ((edge_pend_q & ~irq_clr) | (irq_lines & ~irq_prev_q)) & EDGE_MASK;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    rpc_d    = rpc_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    depth_d  = depth_q;
    case (state_q)
      IDLE: begin
        if (take_exc || take_irq) begin
          if (depth_q == DEPTH_MAX) begin
            state_d = LOCKUP;
          end else begin
            state_d = FLUSH;
            cnt_d   = 4'd0;
            mpie_d  = mie_q;
            mie_d   = 1'b0;
            depth_d = depth_q + 4'd1;
            if (take_exc) begin
              mepc_d   = exc_pc;
              mcause_d = {27'd0, exc_code};
              mtval_d  = exc_tval;
              rpc_d    = vec_base;
            end else begin
              mepc_d   = boundary_next_pc;
              mcause_d = irq_cause;
              mtval_d  = 32'd0;
              rpc_d    = irq_target;
            end
          end
        end else if (take_mret) begin
          state_d = FLUSH;
          cnt_d   = 4'd0;
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          depth_d = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;
          rpc_d   = mepc_q;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) state_d = REDIRECT;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      LOCKUP:  state_d = LOCKUP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
      mtval_q     <= 32'd0;
      rpc_q       <= 32'd0;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      depth_q     <= 4'd0;
      irq_prev_q  <= '0;
      edge_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      rpc_q       <= rpc_d;
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      depth_q     <= depth_d;
      irq_prev_q  <= irq_lines;
      edge_pend_q <= edge_pend_d;
    end
  end

  assign exc_ready      = (state_q == IDLE);
  assign flush          = (state_q == FLUSH) || (state_q == LOCKUP);
  assign redirect_valid = (state_q == REDIRECT);
  assign lockup         = (state_q == LOCKUP);
  assign redirect_pc    = rpc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;
  assign mstatus_mie    = mie_q;
  assign mstatus_mpie   = mpie_q;
  assign trap_depth     = depth_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed trap/MRET/interrupt scenarios followed by
// randomized events, checked against a transaction-level model of the trap CSRs.
module tb_trap_controller;

  localparam int unsigned NIRQ  = 16;
  localparam logic [15:0] EDGE  = 16'h0008;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned NEST  = 2;

  logic        clk, rst_n;
  logic        exc_valid, exc_ready;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_tval;
  logic [15:0] irq_lines, irq_mask, irq_pending;
  logic        boundary_valid, mret_valid;
  logic [31:0] boundary_next_pc, mtvec;
  logic        flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc, mepc, mcause, mtval;
  logic        mstatus_mie, mstatus_mpie, lockup;
  logic [3:0]  trap_depth;

  trap_controller #(.NUM_IRQ(NIRQ), .IRQ_EDGE(EDGE), .FLUSH_CYCLES(FLUSH), .MAX_NEST(NEST)) dut (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_ready(exc_ready),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_lines(irq_lines), .irq_mask(irq_mask), .boundary_valid(boundary_valid),
    .boundary_next_pc(boundary_next_pc), .mret_valid(mret_valid), .mtvec(mtvec),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .trap_depth(trap_depth),
    .lockup(lockup), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model of the trap CSRs, updated once per accepted event
  logic        m_mie, m_mpie;
  int          m_depth;
  logic [31:0] m_mepc, m_mcause, m_mtval;
  logic [15:0] m_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_pend();
    return (irq_lines & ~EDGE) | m_edge;
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_depth = 0;
    m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0; m_edge = 16'd0;
  endtask

  task automatic chk_csrs(input string tag);
    chk({tag, ".mepc"},   mepc,   m_mepc);
    chk({tag, ".mcause"}, mcause, m_mcause);
    chk({tag, ".mtval"},  mtval,  m_mtval);
    chk({tag, ".mie"},    32'(mstatus_mie),  32'(m_mie));
    chk({tag, ".mpie"},   32'(mstatus_mpie), 32'(m_mpie));
    chk({tag, ".depth"},  32'(trap_depth),   32'(m_depth));
    chk({tag, ".pend"},   32'(irq_pending),  32'(model_pend()));
  endtask

  task automatic idle_inputs();
    exc_valid = 1'b0; mret_valid = 1'b0; boundary_valid = 1'b0; redirect_ready = 1'b0;
  endtask

  // Requests already driven; accept on next edge, then walk flush and redirect
  task automatic accept_and_finish(input string tag, input logic [31:0] tgt, input int rdy_delay);
    int n;
    @(posedge clk);
    @(negedge clk);
    exc_valid = 1'b0; mret_valid = 1'b0; boundary_valid = 1'b0;
    chk({tag, ".ready_busy"}, 32'(exc_ready), 32'd0);
    chk_csrs(tag);
    n = 0;
    while (flush === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".flush_len"}, 32'(n), 32'(FLUSH));
    chk({tag, ".rvalid"}, 32'(redirect_valid), 32'd1);
    chk({tag, ".rpc"}, redirect_pc, tgt);
    for (int k = 0; k < rdy_delay; k++) begin
      @(negedge clk);
      chk({tag, ".rvalid_hold"}, 32'(redirect_valid), 32'd1);
      chk({tag, ".rpc_hold"}, redirect_pc, tgt);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    chk({tag, ".rvalid_off"}, 32'(redirect_valid), 32'd0);
    chk({tag, ".ready_idle"}, 32'(exc_ready), 32'd1);
  endtask

  task automatic do_exc(input string tag, input logic [4:0] code, input logic [31:0] pc,
                        input logic [31:0] tval, input int rdy);
    exc_code = code; exc_pc = pc; exc_tval = tval; exc_valid = 1'b1;
    m_mepc = pc; m_mcause = 32'(code); m_mtval = tval;
    m_mpie = m_mie; m_mie = 1'b0; m_depth++;
    accept_and_finish(tag, mtvec & ~32'h3, rdy);
  endtask

  task automatic do_mret(input string tag, input int rdy);
    logic [31:0] tgt;
    tgt = m_mepc;
    m_mie = m_mpie; m_mpie = 1'b1;
    if (m_depth > 0) m_depth--;
    mret_valid = 1'b1;
    accept_and_finish(tag, tgt, rdy);
  endtask

  task automatic do_irq(input string tag, input logic [31:0] npc, input int rdy);
    logic [15:0] elig;
    int win;
    int cause;
    logic [31:0] tgt;
    elig = model_pend() & irq_mask;
    boundary_valid = 1'b1; boundary_next_pc = npc;
    if (!m_mie || elig == 16'd0) begin
      @(negedge clk);
      boundary_valid = 1'b0;
      chk({tag, ".no_take_ready"}, 32'(exc_ready), 32'd1);
      chk({tag, ".no_take_flush"}, 32'(flush), 32'd0);
      chk_csrs({tag, ".no_take"});
    end else begin
      win = 0;
      while (!elig[win]) win++;
      cause = 16 + win;
      m_mepc = npc; m_mcause = 32'h8000_0000 + 32'(cause); m_mtval = 32'd0;
      m_mpie = m_mie; m_mie = 1'b0; m_depth++;
      m_edge[win] = 1'b0;
      tgt = (mtvec & ~32'h3) + ((mtvec[1:0] == 2'b01) ? 32'(4 * cause) : 32'd0);
      accept_and_finish(tag, tgt, rdy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, rdy;
    rst_n = 1'b0;
    idle_inputs();
    exc_code = 5'd0; exc_pc = 32'd0; exc_tval = 32'd0;
    irq_lines = 16'd0; irq_mask = 16'd0;
    boundary_next_pc = 32'd0; mtvec = 32'h8000_0001;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset.flush", 32'(flush), 32'd0);
    chk("reset.rvalid", 32'(redirect_valid), 32'd0);
    chk("reset.lockup", 32'(lockup), 32'd0);
    chk("reset.rpc", redirect_pc, 32'd0);
    chk_csrs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.ready", 32'(exc_ready), 32'd1);

    // Two MRETs from reset raise mie through mpie
    do_mret("mret_en0", 0);
    do_mret("mret_en1", 0);

    do_exc("exc_basic", 5'd2, 32'h100, 32'hDEAD_BEEF, 0);
    do_mret("exc_basic_ret", 1);

    irq_lines = 16'h0006; irq_mask = 16'h0006;
    do_irq("irq_vec", 32'h204, 5);
    irq_lines = 16'd0;
    do_mret("irq_vec_ret", 0);

    // Edge line latched while interrupts are disabled
    do_exc("edge_pre", 5'd3, 32'h210, 32'd0, 0);
    irq_mask = 16'h0008; irq_lines = 16'h0008;
    boundary_valid = 1'b1; boundary_next_pc = 32'h220;
    @(negedge clk);
    irq_lines = 16'd0;
    m_edge = 16'h0008;
    chk("edge_masked.flush", 32'(flush), 32'd0);
    @(negedge clk);
    boundary_valid = 1'b0;
    chk("edge_latched", 32'(irq_pending), 32'h0008);
    do_mret("edge_ret", 0);
    do_irq("edge_take", 32'h300, 0);
    chk("edge_cleared", 32'(irq_pending), 32'd0);
    do_mret("edge_take_ret", 0);

    // Exception and interrupt in the same cycle
    irq_lines = 16'h0001; irq_mask = 16'h0001;
    boundary_valid = 1'b1; boundary_next_pc = 32'h400;
    do_exc("coll_exc", 5'd5, 32'h500, 32'h55, 0);
    do_mret("coll_ret", 2);
    do_irq("coll_irq", 32'h504, 0);
    do_mret("coll_irq_ret", 0);
    irq_lines = 16'd0;

    for (int it = 0; it < 60; it++) begin
      mtvec = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      irq_lines = 16'($urandom) & ~EDGE;
      irq_mask = 16'($urandom);
      boundary_next_pc = $urandom & 32'hFFFF_FFFC;
      kind = $urandom_range(0, 2);
      rdy = $urandom_range(0, 3);
      if (kind == 0 && m_depth < NEST) begin
        if ($urandom_range(0, 1) == 1) begin
          mret_valid = 1'b1; boundary_valid = 1'b1;
        end
        do_exc("rnd_exc", 5'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, rdy);
      end else if (kind == 1 || m_depth >= NEST) begin
        boundary_valid = 1'($urandom_range(0, 1));
        do_mret("rnd_mret", rdy);
      end else begin
        do_irq("rnd_irq", boundary_next_pc, rdy);
      end
    end
    irq_lines = 16'd0;

    // Reset in the middle of a flush
    exc_code = 5'd7; exc_pc = 32'h600; exc_tval = 32'h6; exc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exc_valid = 1'b0;
    chk("midrst.flush_before", 32'(flush), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.flush", 32'(flush), 32'd0);
    chk_csrs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst.no_redirect", 32'(redirect_valid), 32'd0);
    end
    chk("midrst.ready", 32'(exc_ready), 32'd1);

    // Nesting beyond the limit locks up
    mtvec = 32'h8000_0001;
    do_exc("nest1", 5'd1, 32'h700, 32'h71, 0);
    do_exc("nest2", 5'd4, 32'h800, 32'h82, 0);
    exc_code = 5'd6; exc_pc = 32'h900; exc_tval = 32'h93; exc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("lock.lockup", 32'(lockup), 32'd1);
      chk("lock.flush", 32'(flush), 32'd1);
      chk("lock.ready", 32'(exc_ready), 32'd0);
      chk("lock.rvalid", 32'(redirect_valid), 32'd0);
      mret_valid = 1'b1;
      redirect_ready = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    chk_csrs("lock");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lockrst.lockup", 32'(lockup), 32'd0);
    chk("lockrst.flush", 32'(flush), 32'd0);
    chk("lockrst.rpc", redirect_pc, 32'd0);
    chk_csrs("lockrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lockrst.ready", 32'(exc_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
